servant_ram_arb: RTL
====================

Name: servant_ram_arb

Overview:
- Two-master Wishbone arbiter that shares one servant_ram-style single-port RAM between master 0 (instruction bus) and master 1 (data bus or DMA).
- Grants one transaction at a time with round-robin fairness and holds the grant until the RAM acks.
- Inserts the one-cycle cyc-low gap the RAM's toggling ack requires.
- Optional watchdog terminates a hung transaction with an error strobe.

Parameters:
- depth, 256: RAM size in bytes. Must match the attached RAM.
- aw, $clog2(depth): byte address width. Word address is [aw-1:2].
- TIMEOUT, 0: watchdog limit in cycles spent in BUSY. 0 disables the watchdog.

Ports:
- i_wb_clk  in  1  clock; all logic on its rising edge
- i_wb_rst  in  1  synchronous active-high reset
- i_m0_adr  in  aw-2  master 0 word address
- i_m0_dat  in  32  master 0 write data
- i_m0_sel  in  4  master 0 byte enables
- i_m0_we  in  1  master 0 write enable
- i_m0_cyc  in  1  master 0 request
- o_m0_rdt  out  32  master 0 read data
- o_m0_ack  out  1  master 0 ack
- o_m0_err  out  1  master 0 watchdog error
- i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc, o_m1_rdt, o_m1_ack, o_m1_err: same widths and meaning as the m0 ports, for master 1
- o_ram_adr  out  aw-2  to RAM address
- o_ram_dat  out  32  to RAM write data
- o_ram_sel  out  4  to RAM byte enables
- o_ram_we  out  1  to RAM write enable
- o_ram_cyc  out  1  to RAM request
- i_ram_rdt  in  32  from RAM read data
- i_ram_ack  in  1  from RAM ack

Behaviour:
- State machine: IDLE, BUSY. Registers:
  - state
  - gnt (1 bit, the granted master)
  - last (1 bit, the master granted most recently)
  - wdog counter, width $clog2(TIMEOUT+1), minimum 1 bit
- Reset (synchronous, i_wb_rst=1 at an edge):
  - state=IDLE, gnt=0, last=1 (master 0 wins the first tie), wdog=0.
  - Reset mid-BUSY abandons the transaction: no ack and no err to either master.
- IDLE:
  - o_ram_cyc=0.
  - Exactly one cyc high: gnt<=that master, state<=BUSY.
  - Both high: gnt<=~last, state<=BUSY.
  - Neither high: stay in IDLE.
- BUSY:
  - o_ram_cyc = i_m[gnt]_cyc.
  - o_ram_adr, o_ram_dat, o_ram_sel and o_ram_we mux from master gnt combinationally. They hold the last granted master's values while IDLE.
- Ack routing:
  - o_m[gnt]_ack = i_ram_ack & state==BUSY.
  - The non-granted master's ack is always 0.
  - o_mX_rdt = i_ram_rdt for both masters, unqualified. Data is valid only with that master's ack.
- On i_ram_ack in BUSY: state<=IDLE, last<=gnt. The forced IDLE cycle drops o_ram_cyc for one cycle, so the RAM's ack register clears before the next grant.
- Abort: if i_m[gnt]_cyc falls in BUSY without an ack, state<=IDLE, last<=gnt, and no ack is issued.
- Latency: request seen in IDLE at cycle N → o_ram_cyc high at N+1 → ack and rdt at the master at N+2 → IDLE at N+3. Peak throughput is one transaction per 3 cycles.
- Watchdog (TIMEOUT>0):
  - wdog clears on entry to BUSY and increments each BUSY cycle without an ack.
  - When wdog==TIMEOUT-1 and no ack: o_m[gnt]_err=1 for one cycle, state<=IDLE, last<=gnt.
  - An ack in the same cycle wins, and err stays 0.
- err is 0 when TIMEOUT=0 and during reset.
- Output reset values: all acks and errs are 0, o_ram_cyc=0.

Decomposition:
- No package needed. State encoding is two localparams (IDLE=1'b0, BUSY=1'b1) local to the module.
- One natural sub-module: servant_rr2, a 2-input round-robin picker. It takes req[1:0] and last, and outputs valid and winner, combinationally.
- The watchdog stays inline.

Test Plan:
- Reset, then only m0 reads word 5 (RAM preloaded 0x12345678) → o_ram_cyc high 1 cycle after the request, o_m0_ack one cycle later with o_m0_rdt=0x12345678, o_m1_ack never set.
- m0 and m1 assert cyc in the same cycle, each holding until acked → m0 served first, m1 granted next. o_ram_cyc low for exactly one cycle between the two grants.
- Both masters request continuously for 12 cycles → grants alternate m0, m1, m0, m1, with 4 acks total and neither master starved.
- m1 writes 0xAABBCCDD with sel=4'b0101, then m0 reads the same address → m0 receives 0xXXBBXXDD-merged data, i.e. the old bytes 3 and 1 kept.
- TIMEOUT=4, RAM ack forced low, m1 requests → o_m1_err pulses one cycle in the 4th BUSY cycle, arbiter back in IDLE, and a subsequent m0 request is served normally.
- Assert i_wb_rst during BUSY → next cycle state IDLE, no ack or err. Afterwards a simultaneous m0/m1 request grants m0 first.

Source files
------------

// File: rtl/servant_rr2.sv
// Two-input round-robin picker: on a tie, the master not granted last time wins.
module servant_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/servant_ram_arb.sv
// Two-master Wishbone arbiter in front of a servant_ram-style single-port RAM.
// One transaction at a time, round-robin, with a forced idle cycle after each grant.
module servant_ram_arb #(
  parameter int depth   = 256,
  parameter int aw      = $clog2(depth),
  parameter int TIMEOUT = 0
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [aw-3:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_cyc,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic [aw-3:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_cyc,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [aw-3:0] o_ram_adr,
  output logic [31:0]   o_ram_dat,
  output logic [3:0]    o_ram_sel,
  output logic          o_ram_we,
  output logic          o_ram_cyc,
  input  logic [31:0]   i_ram_rdt,
  input  logic          i_ram_ack
);

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam int WdogW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [WdogW-1:0] wdog_q, wdog_d;

  logic rr_valid;
  logic rr_winner;
  logic busy;
  logic cur_cyc;
  logic ack;
  logic timeout;

  servant_rr2 u_rr (
    .req    ({i_m1_cyc, i_m0_cyc}),
    .last   (last_q),
    .valid  (rr_valid),
    .winner (rr_winner)
  );

  // Reset gates the master-facing strobes so an abandoned transaction stays silent.
  always_comb begin
    busy    = (state_q == StBusy);
    cur_cyc = gnt_q ? i_m1_cyc : i_m0_cyc;
    ack     = busy & i_ram_ack & ~i_wb_rst;
    timeout = (TIMEOUT != 0) && busy && cur_cyc && !i_ram_ack && !i_wb_rst &&
              (wdog_q == WdogMax);

    o_ram_cyc = busy & cur_cyc & ~i_wb_rst;
    o_ram_adr = gnt_q ? i_m1_adr : i_m0_adr;
    o_ram_dat = gnt_q ? i_m1_dat : i_m0_dat;
    o_ram_sel = gnt_q ? i_m1_sel : i_m0_sel;
    o_ram_we  = gnt_q ? i_m1_we  : i_m0_we;

    o_m0_rdt = i_ram_rdt;
    o_m1_rdt = i_ram_rdt;
    o_m0_ack = ack & ~gnt_q;
    o_m1_ack = ack & gnt_q;
    o_m0_err = timeout & ~gnt_q;
    o_m1_err = timeout & gnt_q;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          gnt_d   = rr_winner;
          state_d = StBusy;
          wdog_d  = '0;
        end
      end
      StBusy: begin
        // Ack, abort and timeout all return to idle so the RAM sees cyc low.
        if (i_ram_ack || !cur_cyc || timeout) begin
          state_d = StIdle;
          last_d  = gnt_q;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule
